// File: rtl/card_auth_pkg.sv
// Shared types and constants for the card authorizer and its balance bank.
package card_auth_pkg;
    localparam int NUM_CARDS = 4;
    localparam int BAL_W     = 8;
    localparam int COST_W    = 3;
    localparam int ID_W      = $clog2(NUM_CARDS);

    localparam logic [BAL_W-1:0] INIT_BAL = 8'd10;
    localparam logic [BAL_W-1:0] BAL_MAX  = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CHECK,
        AUTH,
        DEBIT,
        DECLINE,
        DONE
    } state_t;

    // Unsigned add that clamps at BAL_MAX; the extra carry bit detects overflow.
    function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                 input logic [BAL_W-1:0] b);
        logic [BAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BAL_W] ? BAL_MAX : sum[BAL_W-1:0];
    endfunction
endpackage

// File: rtl/card_authorizer_if.sv
// Vending-machine / top-up bus between the requester and the card authorizer.
interface card_authorizer_if;
    import card_auth_pkg::*;

    logic              card_in;
    logic [ID_W-1:0]   card_id;
    logic [COST_W-1:0] cost;
    logic              vend;
    logic              failed_tran;
    logic              topup;
    logic [BAL_W-1:0]  topup_amt;
    logic              valid_tran;
    logic              declined;
    logic [BAL_W-1:0]  balance;

    modport master (
        output card_in, card_id, cost, vend, failed_tran, topup, topup_amt,
        input  valid_tran, declined, balance
    );

    modport slave (
        input  card_in, card_id, cost, vend, failed_tran, topup, topup_amt,
        output valid_tran, declined, balance
    );
endinterface

// File: rtl/card_authorizer_balance_bank.sv
// Per-card balance register file: one async read port, one write port that
// either debits or does a saturating credit.
module balance_bank
    import card_auth_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ID_W-1:0]  rd_idx_i,
    output logic [BAL_W-1:0] rd_data_o,
    input  logic             debit_i,
    input  logic             credit_i,
    input  logic [ID_W-1:0]  wr_idx_i,
    input  logic [BAL_W-1:0] amt_i
);
    logic [NUM_CARDS-1:0][BAL_W-1:0] bal_q;
    logic [BAL_W-1:0]                wr_old;

    assign rd_data_o = bal_q[rd_idx_i];
    assign wr_old    = bal_q[wr_idx_i];

    // Balance storage; debit clamps at zero so a stale cost can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bal_q <= {NUM_CARDS{INIT_BAL}};
        end else if (debit_i) begin
            bal_q[wr_idx_i] <= (wr_old >= amt_i) ? wr_old - amt_i : '0;
        end else if (credit_i) begin
            bal_q[wr_idx_i] <= sat_add(wr_old, amt_i);
        end
    end
endmodule

// File: rtl/card_authorizer.sv
// Card authorizer: checks funds for a vending request, debits on VEND,
// and accepts top-ups while idle with no card inserted.
module card_authorizer
    import card_auth_pkg::*;
(
    input logic               clk_i,
    input logic               rst_i,
    card_authorizer_if.slave  bus
);
    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [COST_W-1:0] cost_q, cost_d;
    logic              valid_q, valid_d;
    logic              decl_q, decl_d;
    logic [BAL_W-1:0]  bal_q, bal_d;

    logic [ID_W-1:0]   rd_idx;
    logic [BAL_W-1:0]  rd_bal;
    logic              debit, credit;
    logic [BAL_W-1:0]  wr_amt;
    logic              funds_ok;

    // In IDLE the live CARD_ID is shown and topped up; afterwards the latched id.
    assign rd_idx   = (state_q == IDLE) ? bus.card_id : id_q;
    assign funds_ok = rd_bal >= BAL_W'(cost_q);
    assign debit    = (state_q == DEBIT);
    assign credit   = (state_q == IDLE) && !bus.card_in && bus.topup;
    assign wr_amt   = debit ? BAL_W'(cost_q) : bus.topup_amt;

    balance_bank u_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_bal),
        .debit_i   (debit),
        .credit_i  (credit),
        .wr_idx_i  (rd_idx),
        .amt_i     (wr_amt)
    );

    // Next-state, capture registers and registered output values.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cost_d  = cost_q;
        unique case (state_q)
            IDLE: begin
                if (bus.card_in) begin
                    id_d    = bus.card_id;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // Card removal aborts before a price is taken.
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else if (bus.cost != '0) begin
                    cost_d  = bus.cost;
                    state_d = CHECK;
                end
            end
            CHECK:   state_d = funds_ok ? AUTH : DECLINE;
            AUTH: begin
                if (bus.failed_tran || !bus.card_in) state_d = DONE;
                else if (bus.vend)                   state_d = DEBIT;
            end
            DEBIT:   state_d = DONE;
            DECLINE: state_d = DONE;
            DONE: begin
                if (!bus.card_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // VALID_TRAN comes up one cycle into AUTH and drops as AUTH is left.
        valid_d = (state_q == AUTH) && (state_d == AUTH);
        decl_d  = (state_q == DECLINE);
        bal_d   = rd_bal;
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            cost_q  <= '0;
            valid_q <= 1'b0;
            decl_q  <= 1'b0;
            bal_q   <= INIT_BAL;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cost_q  <= cost_d;
            valid_q <= valid_d;
            decl_q  <= decl_d;
            bal_q   <= bal_d;
        end
    end

    assign bus.valid_tran = valid_q;
    assign bus.declined   = decl_q;
    assign bus.balance    = bal_q;
endmodule

// File: tb/tb_card_authorizer.sv
// Directed bench for card_authorizer with a session-timeline reference model.
module tb_card_authorizer;
    import card_auth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    card_authorizer_if bus_if();

    card_authorizer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a session is a card insertion; once a price is taken the
    // age counts edges, the decision lands at age 1 and outputs appear from age 2.
    int   m_bal [NUM_CARDS];
    int   m_sess;      // 0 no card, 1 waiting price, 2 priced, 4 debit due, 5 closed
    int   m_id, m_cost, m_age;
    bit   m_ok;
    int   nb;
    bit   nv, nd;
    bit   e_valid, e_decl;
    int   e_bal;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_bal[i]) m_bal[i] = 10;
            m_sess = 0; m_id = 0; m_cost = 0; m_age = 0; m_ok = 0;
            e_valid = 0; e_decl = 0; e_bal = 10;
        end else begin
            nb = (m_sess == 0) ? m_bal[bus_if.card_id] : m_bal[m_id];
            nv = 0; nd = 0;
            case (m_sess)
                0: if (bus_if.card_in) begin
                       m_id = bus_if.card_id; m_sess = 1;
                   end else if (bus_if.topup) begin
                       m_bal[bus_if.card_id] = m_bal[bus_if.card_id] + bus_if.topup_amt;
                       if (m_bal[bus_if.card_id] > 255) m_bal[bus_if.card_id] = 255;
                   end
                1: if (!bus_if.card_in) m_sess = 0;
                   else if (bus_if.cost != 0) begin
                       m_cost = bus_if.cost; m_age = 0; m_sess = 2;
                   end
                2: begin
                       m_age++;
                       if (m_age == 1)                                  m_ok = (m_bal[m_id] >= m_cost);
                       else if (!m_ok)                                  begin nd = 1; m_sess = 5; end
                       else if (bus_if.failed_tran || !bus_if.card_in)  m_sess = 5;
                       else if (bus_if.vend)                            m_sess = 4;
                       else                                             nv = 1;
                   end
                4: begin m_bal[m_id] = m_bal[m_id] - m_cost; m_sess = 5; end
                5: if (!bus_if.card_in) m_sess = 0;
                default: m_sess = 0;
            endcase
            e_valid = nv; e_decl = nd; e_bal = nb;
        end
    end

    // Every-cycle compare against the model, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        chk("valid_tran", bus_if.valid_tran, e_valid);
        chk("declined",   bus_if.declined,   e_decl);
        chk("balance",    bus_if.balance,    e_bal);
        chk("exclusive",  bus_if.valid_tran & bus_if.declined, 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Show one account's balance while idle and compare to a literal.
    task automatic peek(input string name, input int id, input int exp);
        bus_if.card_in = 1'b0;
        bus_if.card_id = ID_W'(id);
        cyc(1);
        chk(name, bus_if.balance, exp);
    endtask

    // One card session. act: 0 vend, 1 failed, 2 vend+failed, 3 pull card in AUTH.
    task automatic txn(input int id, input int c, input int act, input int new_id,
                       output bit got_valid, output bit got_decl);
        bus_if.card_id = ID_W'(id);
        bus_if.card_in = 1'b1;
        cyc(1);
        bus_if.cost = COST_W'(c);
        got_valid = 0; got_decl = 0;
        for (int i = 0; i < 8 && !got_valid && !got_decl; i++) begin
            cyc(1);
            got_valid = bus_if.valid_tran;
            got_decl  = bus_if.declined;
        end
        if (!got_valid && !got_decl) begin
            n_chk++; n_fail++;
            $display("FAIL txn_response: got none expected valid or declined (card %0d)", id);
        end
        if (got_valid) begin
            bus_if.card_id = ID_W'(new_id);
            bus_if.vend        = (act == 0 || act == 2);
            bus_if.failed_tran = (act == 1 || act == 2);
            if (act == 3) bus_if.card_in = 1'b0;
            cyc(1);
            bus_if.vend = 1'b0; bus_if.failed_tran = 1'b0;
        end else if (got_decl) begin
            cyc(1);
            chk("decline_pulse_width", bus_if.declined, 0);
        end
        bus_if.card_in = 1'b0;
        bus_if.cost    = '0;
        cyc(3);
    endtask

    bit gv, gd;

    initial begin
        bus_if.card_in = 0; bus_if.card_id = 0; bus_if.cost = 0; bus_if.vend = 0;
        bus_if.failed_tran = 0; bus_if.topup = 0; bus_if.topup_amt = 0;
        rst = 1'b1;
        cyc(2);
        chk("reset_valid",   bus_if.valid_tran, 0);
        chk("reset_decl",    bus_if.declined,   0);
        chk("reset_balance", bus_if.balance,    10);
        rst = 1'b0;

        // Card 0, COST=3: VALID_TRAN two edges after the price is taken.
        bus_if.card_id = 0; bus_if.card_in = 1; cyc(1);
        bus_if.cost = 3; cyc(1);
        chk("a_valid_e_n",  bus_if.valid_tran, 0); cyc(1);
        chk("a_valid_e_n1", bus_if.valid_tran, 0); cyc(1);
        chk("a_valid_e_n2", bus_if.valid_tran, 1);
        bus_if.vend = 1; cyc(1); bus_if.vend = 0;
        chk("a_valid_debit", bus_if.valid_tran, 0);
        cyc(2);
        chk("a_balance_7", bus_if.balance, 7);
        bus_if.card_in = 0; bus_if.cost = 0; cyc(2);
        peek("a_bal0", 0, 7);

        // Card 1: debit 6, then a second 6 is declined.
        txn(1, 6, 0, 1, gv, gd);
        chk("b1_valid", gv, 1);
        txn(1, 6, 0, 1, gv, gd);
        chk("b2_declined", gd, 1);
        chk("b2_no_valid", gv, 0);
        peek("b_bal1", 1, 4);

        // VEND and FAILED_TRAN together: no debit.
        txn(3, 5, 2, 3, gv, gd);
        peek("c_bal3", 3, 10);

        // Top-ups: saturation, plain add, ignored in LATCH, card wins same cycle.
        bus_if.card_id = 2; bus_if.topup_amt = 250; bus_if.topup = 1; cyc(1); bus_if.topup = 0;
        peek("d_bal2_sat", 2, 255);
        bus_if.card_id = 1; bus_if.topup_amt = 3; bus_if.topup = 1; cyc(1); bus_if.topup = 0;
        peek("d_bal1_add", 1, 7);
        bus_if.card_id = 1; bus_if.card_in = 1; cyc(1);
        bus_if.topup_amt = 5; bus_if.topup = 1; cyc(1); bus_if.topup = 0;
        bus_if.card_in = 0; cyc(2);
        peek("d_latch_ignored", 1, 7);
        bus_if.card_id = 0; bus_if.card_in = 1; bus_if.topup_amt = 1; bus_if.topup = 1; cyc(1);
        bus_if.topup = 0; bus_if.card_in = 0; cyc(2);
        peek("d_card_priority", 0, 7);

        // Exact-funds boundary, then an empty account, then card pulled in AUTH.
        txn(1, 7, 0, 1, gv, gd);
        chk("e_exact_valid", gv, 1);
        peek("e_bal1_zero", 1, 0);
        txn(1, 1, 0, 1, gv, gd);
        chk("e_empty_declined", gd, 1);
        txn(0, 2, 3, 0, gv, gd);
        peek("e_pull_no_debit", 0, 7);

        // Reset in the cycle after VEND: no debit, all balances restored.
        bus_if.card_id = 0; bus_if.card_in = 1; cyc(1);
        bus_if.cost = 1; cyc(3);
        chk("f_valid_before_vend", bus_if.valid_tran, 1);
        bus_if.vend = 1; cyc(1); bus_if.vend = 0;
        rst = 1; cyc(1); rst = 0;
        chk("f_valid_after_reset", bus_if.valid_tran, 0);
        // Card still inserted is a fresh session.
        cyc(1); cyc(3);
        chk("f_reinsert_valid", bus_if.valid_tran, 1);
        bus_if.card_in = 0; bus_if.cost = 0; cyc(3);
        for (int i = 0; i < NUM_CARDS; i++) peek($sformatf("f_bal%0d", i), i, 10);

        // CARD_ID changes mid-AUTH do not redirect the debit.
        txn(0, 2, 0, 3, gv, gd);
        peek("g_bal0", 0, 8);
        peek("g_bal3", 3, 10);

        // Top-up landing exactly on the ceiling, then saturating past it.
        bus_if.card_id = 3; bus_if.topup_amt = 245; bus_if.topup = 1; cyc(1); bus_if.topup = 0;
        peek("h_bal3_exact", 3, 255);
        bus_if.card_id = 3; bus_if.topup_amt = 1; bus_if.topup = 1; cyc(1); bus_if.topup = 0;
        peek("h_bal3_hold", 3, 255);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/card_authorizer.md
CARD_AUTHORIZER -- requirements
Module: card_authorizer

Interface
REQ-001 CLK  input  1  single system clock; all state changes on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 CARD_IN  input  1  card present; the same signal the vending_machine receives.
REQ-004 CARD_ID  input  2  card identity; selects one of 4 accounts; also the account for TOPUP.
REQ-005 COST  input  3  price from vending_machine; nonzero = authorization request.
REQ-006 VEND  input  1  from vending_machine; commits the debit.
REQ-007 FAILED_TRAN  input  1  from vending_machine; aborts the transaction with no debit.
REQ-008 TOPUP  input  1  single-cycle request to credit the CARD_ID account.
REQ-009 TOPUP_AMT  input  8  credit amount, unsigned.
REQ-010 VALID_TRAN  output  1  to vending_machine; funds authorized.
REQ-011 DECLINED  output  1  one-cycle pulse; insufficient funds.
REQ-012 BALANCE  output  8  balance of the selected account; registered.

Function
REQ-013 The block SHALL implement these states: IDLE, LATCH, CHECK, AUTH, DEBIT, DECLINE, DONE.
REQ-014 IDLE: when CARD_IN=1 -> LATCH, capturing CARD_ID into id_reg. Later CARD_ID changes are ignored until the next IDLE.
REQ-015 LATCH: when COST!=0, capture cost_reg -> CHECK. When CARD_IN=0 -> IDLE. Otherwise stay in LATCH.
REQ-016 CHECK: one cycle. Go to AUTH if balance[id_reg] >= cost_reg (unsigned, 8-bit compare, cost zero-extended). Otherwise go to DECLINE.
REQ-017 Latency: COST is first sampled nonzero at edge n. The decision is made at edge n+1. VALID_TRAN or DECLINED is high from edge n+2.
REQ-018 AUTH: VALID_TRAN=1 throughout.
  - FAILED_TRAN=1 or CARD_IN=0 -> DONE, no debit.
  - Otherwise VEND=1 -> DEBIT.
  - VEND and FAILED_TRAN together: FAILED_TRAN wins.
REQ-019 DEBIT: one cycle; balance[id_reg] <= balance[id_reg] - cost_reg; VALID_TRAN=0; -> DONE. The debit completes even if CARD_IN falls during this cycle.
REQ-020 Underflow is impossible by REQ-016. The balance SHALL never wrap below 0.
REQ-021 DECLINE: DECLINED=1 for exactly one cycle -> DONE.
REQ-022 DONE: all pulse outputs 0; -> IDLE when CARD_IN=0. A new card requires CARD_IN to drop first.
REQ-023 TOPUP is honored only in IDLE with CARD_IN=0. balance[CARD_ID] <= min(balance + TOPUP_AMT, 255), computed with 9-bit saturation. TOPUP in any other state is ignored.
REQ-024 TOPUP and CARD_IN rising in the same IDLE cycle: the card takes priority and TOPUP is ignored.
REQ-025 BALANCE SHALL show:
  - balance[CARD_ID] in IDLE;
  - balance[id_reg] in all other states, updated the cycle after a debit or top-up write.
REQ-026 VALID_TRAN and DECLINED SHALL be registered, glitch-free, and never high together.

Reset
REQ-027 RESET=1 SHALL force:
  - state=IDLE;
  - VALID_TRAN=0, DECLINED=0;
  - id_reg=0, cost_reg=0;
  - all four balances = 8'd10;
  - BALANCE = 8'd10.
REQ-028 RESET SHALL override all other inputs in the same cycle. If RESET occurs mid-AUTH or mid-DEBIT, no debit is performed.
REQ-029 After RESET is released, a card that is still inserted SHALL be treated as a new insertion (IDLE -> LATCH).

Structure
REQ-030 The shared package card_auth_pkg SHALL hold:
  - the state enumeration;
  - NUM_CARDS=4, BAL_W=8, COST_W=3, INIT_BAL=8'd10, BAL_MAX=8'd255.
REQ-031 Sub-module balance_bank SHALL hold the 4x8 register file, with:
  - one combinational read port;
  - one write port (debit or saturating credit, mutually exclusive);
  - a synchronous reset to INIT_BAL.
REQ-032 The FSM and output registers SHALL live in card_authorizer.

Verification
REQ-033 Reset, card 0, COST=3, VEND at the second AUTH cycle -> VALID_TRAN rises 2 cycles after COST, then balance[0]=7 and BALANCE=7.
REQ-034 Card 1 with balance 10: debit by COST=6 (VEND), remove the card, reinsert, COST=6 -> second attempt gives DECLINED for one cycle, no VALID_TRAN, balance stays 4.
REQ-035 In AUTH, assert VEND and FAILED_TRAN in the same cycle -> DONE, balance unchanged at 10.
REQ-036 TOPUP_AMT=250 on card 2 in IDLE -> balance[2]=255 (saturated). TOPUP asserted while a card is in LATCH -> ignored.
REQ-037 RESET in the cycle after VEND while in AUTH -> IDLE, all balances 10, VALID_TRAN=0.
REQ-038 Change CARD_ID from 0 to 3 while in AUTH, then VEND with COST=2 -> debit hits card 0 only (balance[0]=8, balance[3]=10).
